sum_share_arbiter: RTL and testbench

//  Round-robin scheduler sharing one serial-load adder among N_REQ SIPO channels.

---
 rtl/sum_share_arbiter.sv | 204 ++++++++++++++++++++
 tb/tb_sum_share_arbiter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/sum_share_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : sum_share_arbiter
//  Description : Round-robin scheduler that shares one serial-load adder among
//                N_REQ SIPO channels. Grants one requesting channel, steers the
//                adder operand mux, sequences the adder enable, pulses that
//                channel's PISO load and signals completion back to it.
//
//                Flow: IDLE -> GRANT -> SUM -> OUT -> RELEASE -> IDLE
//
//  Ports       : clk            system clock, rising edge
//                rst_n          asynchronous active-low reset
//                i_req          per-channel level request
//                i_sum_ready    adder result valid (sampled only in SUM)
//                o_gnt          one-hot grant, high GRANT..OUT
//                o_sel          index of the granted channel (adder operand mux)
//                o_sum_enable   adder enable, high only in SUM
//                o_piso_enable  one-hot 1-cycle PISO load pulse
//                o_done         one-hot 1-cycle completion pulse
//                o_busy         high whenever the FSM is not IDLE
//                o_err          sticky SUM timeout flag
//
//  Build option: SUM_TIMEOUT_EN - when defined, a SUM phase that waits
//                TIMEOUT_CYCLES cycles without i_sum_ready is abandoned
//                (no PISO load, done still pulses) and o_err is set until
//                reset. When undefined, SUM waits indefinitely and o_err = 0.
//
//  Revision    : 1.0 - initial release
// ============================================================================
module sum_share_arbiter #(
    parameter int N_REQ          = 4,
    parameter int IDX_W          = 2,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   i_req,
    input  logic               i_sum_ready,
    output logic [N_REQ-1:0]   o_gnt,
    output logic [IDX_W-1:0]   o_sel,
    output logic               o_sum_enable,
    output logic [N_REQ-1:0]   o_piso_enable,
    output logic [N_REQ-1:0]   o_done,
    output logic               o_busy,
    output logic               o_err
);

    // Elaboration-time guard on the parameter set.
    if (N_REQ < 2 || N_REQ > 8 || IDX_W != $clog2(N_REQ) || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("sum_share_arbiter: illegal parameter combination");
    end

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_GRANT   = 3'd1,
        S_SUM     = 3'd2,
        S_OUT     = 3'd3,
        S_RELEASE = 3'd4
    } state_t;

    state_t             r_state;
    logic [IDX_W-1:0]   r_ptr;
    logic [IDX_W-1:0]   r_sel;
    logic [N_REQ-1:0]   r_gnt;
    logic               r_sum_en;
    logic [N_REQ-1:0]   r_piso;
    logic [N_REQ-1:0]   r_done;
    logic               r_busy;
    logic               r_err;

    logic               w_any_req;
    logic [IDX_W-1:0]   w_winner;

    // First requesting channel after the last-served one, wrapping modulo N_REQ.
    // The last-served channel itself is checked last, so it can only win when
    // nobody else is asking.
    function automatic logic [IDX_W-1:0] f_pick(input logic [N_REQ-1:0] req,
                                                input logic [IDX_W-1:0] ptr);
        logic [IDX_W-1:0] win;
        logic             found;
        int               idx;
        win   = '0;
        found = 1'b0;
        for (int i = 1; i <= N_REQ; i++) begin
            idx = (int'(ptr) + i) % N_REQ;
            if (!found && req[IDX_W'(idx)]) begin
                found = 1'b1;
                win   = IDX_W'(idx);
            end
        end
        return win;
    endfunction

    function automatic logic [N_REQ-1:0] f_onehot(input logic [IDX_W-1:0] s);
        return {{(N_REQ-1){1'b0}}, 1'b1} << s;
    endfunction

    assign w_any_req = |i_req;
    assign w_winner  = f_pick(i_req, r_ptr);

`ifdef SUM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] r_cnt;
    logic             w_timeout;

    // Counter holds the number of SUM cycles already spent without a result;
    // the cycle in which it equals TIMEOUT_CYCLES-1 is the last one allowed.
    assign w_timeout = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

    // Single FSM block; every output is a register loaded with the value that
    // belongs to the state being entered, so outputs never depend on inputs
    // combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_ptr    <= IDX_W'(N_REQ - 1);
            r_sel    <= '0;
            r_gnt    <= '0;
            r_sum_en <= 1'b0;
            r_piso   <= '0;
            r_done   <= '0;
            r_busy   <= 1'b0;
            r_err    <= 1'b0;
`ifdef SUM_TIMEOUT_EN
            r_cnt    <= '0;
`endif
        end else begin
            // Pulse outputs default low; they are raised only for one state.
            r_piso <= '0;
            r_done <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_sel   <= w_winner;
                        r_gnt   <= f_onehot(w_winner);
                        r_busy  <= 1'b1;
                        r_state <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    r_sum_en <= 1'b1;
`ifdef SUM_TIMEOUT_EN
                    r_cnt    <= '0;
`endif
                    r_state  <= S_SUM;
                end
                S_SUM: begin
                    if (i_sum_ready) begin
                        r_sum_en <= 1'b0;
                        r_piso   <= f_onehot(r_sel);
                        r_state  <= S_OUT;
`ifdef SUM_TIMEOUT_EN
                    end else if (w_timeout) begin
                        // Abandon the sum: no PISO load, but the channel
                        // still gets its done pulse.
                        r_sum_en <= 1'b0;
                        r_gnt    <= '0;
                        r_done   <= f_onehot(r_sel);
                        r_err    <= 1'b1;
                        r_state  <= S_RELEASE;
                    end else begin
                        r_cnt    <= r_cnt + 1'b1;
`endif
                    end
                end
                S_OUT: begin
                    r_gnt   <= '0;
                    r_done  <= f_onehot(r_sel);
                    r_state <= S_RELEASE;
                end
                S_RELEASE: begin
                    r_ptr   <= r_sel;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_gnt    <= '0;
                    r_sum_en <= 1'b0;
                    r_busy   <= 1'b0;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end

    assign o_gnt         = r_gnt;
    assign o_sel         = r_sel;
    assign o_sum_enable  = r_sum_en;
    assign o_piso_enable = r_piso;
    assign o_done        = r_done;
    assign o_busy        = r_busy;

`ifdef SUM_TIMEOUT_EN
    assign o_err = r_err;
`else
    // Without the timeout there is nothing to flag.
    logic w_err_unused;
    assign w_err_unused = r_err;
    assign o_err        = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sum_share_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sum_share_arbiter
//  Description : Directed self-checking bench for sum_share_arbiter
//                (N_REQ=4, TIMEOUT_CYCLES=16). Inputs change and outputs are
//                sampled on the falling clock edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sum_share_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] i_req;
    logic       i_sum_ready;
    logic [3:0] o_gnt;
    logic [1:0] o_sel;
    logic       o_sum_enable;
    logic [3:0] o_piso_enable;
    logic [3:0] o_done;
    logic       o_busy;
    logic       o_err;

    int total = 0;
    int bad   = 0;

    sum_share_arbiter #(
        .N_REQ          (4),
        .IDX_W          (2),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_req         (i_req),
        .i_sum_ready   (i_sum_ready),
        .o_gnt         (o_gnt),
        .o_sel         (o_sel),
        .o_sum_enable  (o_sum_enable),
        .o_piso_enable (o_piso_enable),
        .o_done        (o_done),
        .o_busy        (o_busy),
        .o_err         (o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Entered at a falling edge one cycle before the expected grant. Walks
    // GRANT, nsum SUM cycles (sum_ready on the last), OUT, RELEASE and the
    // following IDLE cycle. sum_req is driven in the first SUM cycle and
    // rel_req in the RELEASE cycle.
    task automatic serve(input int ch, input int nsum,
                         input logic [3:0] sum_req, input logic [3:0] rel_req);
        logic [3:0] oh;
        oh = 4'b0001 << ch;
        @(negedge clk);
        chk("grant_gnt",   32'(o_gnt), 32'(oh));
        chk("grant_sel",   32'(o_sel), 32'(ch));
        chk("grant_sumen", 32'(o_sum_enable), 32'd0);
        chk("grant_busy",  32'(o_busy), 32'd1);
        for (int i = 1; i <= nsum; i++) begin
            @(negedge clk);
            chk("sum_sumen", 32'(o_sum_enable), 32'd1);
            chk("sum_gnt",   32'(o_gnt), 32'(oh));
            chk("sum_piso",  32'(o_piso_enable), 32'd0);
            if (i == 1)    i_req = sum_req;
            if (i == nsum) i_sum_ready = 1'b1;
        end
        @(negedge clk);
        i_sum_ready = 1'b0;
        chk("out_piso",  32'(o_piso_enable), 32'(oh));
        chk("out_sumen", 32'(o_sum_enable), 32'd0);
        chk("out_gnt",   32'(o_gnt), 32'(oh));
        chk("out_done",  32'(o_done), 32'd0);
        @(negedge clk);
        chk("rel_done", 32'(o_done), 32'(oh));
        chk("rel_gnt",  32'(o_gnt), 32'd0);
        chk("rel_piso", 32'(o_piso_enable), 32'd0);
        chk("rel_busy", 32'(o_busy), 32'd1);
        i_req = rel_req;
        @(negedge clk);
        chk("idle_busy", 32'(o_busy), 32'd0);
        chk("idle_gnt",  32'(o_gnt), 32'd0);
        chk("idle_done", 32'(o_done), 32'd0);
    endtask

    initial begin
        rst_n       = 1'b0;
        i_req       = 4'b1111;
        i_sum_ready = 1'b0;

        // Reset holds everything low even with all requests up.
        @(negedge clk);
        @(negedge clk);
        chk("rst_gnt",   32'(o_gnt), 32'd0);
        chk("rst_sel",   32'(o_sel), 32'd0);
        chk("rst_sumen", 32'(o_sum_enable), 32'd0);
        chk("rst_piso",  32'(o_piso_enable), 32'd0);
        chk("rst_done",  32'(o_done), 32'd0);
        chk("rst_busy",  32'(o_busy), 32'd0);
        chk("rst_err",   32'(o_err), 32'd0);

        // Fairness: all held high, order 0,1,2,3,0 starting from reset pointer 3.
        rst_n = 1'b1;
        serve(0, 1, 4'b1111, 4'b1111);
        serve(1, 1, 4'b1111, 4'b1111);
        serve(2, 1, 4'b1111, 4'b1111);
        serve(3, 1, 4'b1111, 4'b1111);
        serve(0, 1, 4'b1111, 4'b1111);

        // Single request, three SUM cycles; pointer is 0 so channel 2.
        i_req = 4'b0100;
        serve(2, 3, 4'b0100, 4'b0000);

        // Idle with no requests: stays put, sum_ready ignored.
        i_sum_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_hold_busy",  32'(o_busy), 32'd0);
        chk("idle_hold_gnt",   32'(o_gnt), 32'd0);
        chk("idle_hold_sumen", 32'(o_sum_enable), 32'd0);
        chk("idle_hold_piso",  32'(o_piso_enable), 32'd0);
        i_sum_ready = 1'b0;

        // Churn: ch1 drops its req during SUM, ch3 and ch0 raise theirs.
        // Pointer after ch1 is 1, so ch3 precedes ch0.
        i_req = 4'b0010;
        serve(1, 2, 4'b1001, 4'b1001);
        serve(3, 1, 4'b1001, 4'b0001);
        serve(0, 1, 4'b0001, 4'b0000);

        // Reset during SUM of channel 2.
        i_req = 4'b0100;
        @(negedge clk);
        chk("mrst_grant", 32'(o_gnt), 32'b0100);
        @(negedge clk);
        chk("mrst_sum", 32'(o_sum_enable), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_async_gnt",   32'(o_gnt), 32'd0);
        chk("mrst_async_sumen", 32'(o_sum_enable), 32'd0);
        chk("mrst_async_busy",  32'(o_busy), 32'd0);
        chk("mrst_async_sel",   32'(o_sel), 32'd0);
        @(negedge clk);
        chk("mrst_piso", 32'(o_piso_enable), 32'd0);
        chk("mrst_done", 32'(o_done), 32'd0);
        // Pointer back to 3 picks ch0; a stale pointer of 0 would pick ch1.
        i_req = 4'b0011;
        rst_n = 1'b1;
        serve(0, 1, 4'b0011, 4'b0010);
        serve(1, 1, 4'b0010, 4'b0000);

`ifdef SUM_TIMEOUT_EN
        // Timeout on ch2 with ch3 waiting; sum_ready never comes.
        i_req = 4'b1100;
        @(negedge clk);
        chk("to_grant", 32'(o_gnt), 32'b0100);
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            chk("to_sumen", 32'(o_sum_enable), 32'd1);
            chk("to_err_low", 32'(o_err), 32'd0);
        end
        @(negedge clk);
        chk("to_done",  32'(o_done), 32'b0100);
        chk("to_piso",  32'(o_piso_enable), 32'd0);
        chk("to_gnt",   32'(o_gnt), 32'd0);
        chk("to_sumen_off", 32'(o_sum_enable), 32'd0);
        chk("to_err",   32'(o_err), 32'd1);
        i_req = 4'b1000;
        @(negedge clk);
        chk("to_idle_busy", 32'(o_busy), 32'd0);
        serve(3, 1, 4'b1000, 4'b0000);
        chk("to_err_sticky", 32'(o_err), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("to_err_cleared", 32'(o_err), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
`else
        // Without the timeout a long SUM simply waits.
        i_req = 4'b0100;
        serve(2, 20, 4'b0100, 4'b0000);
        chk("nto_err", 32'(o_err), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
